// File: rtl/seven_segment_pkg.sv
// Shared constants and types for the seven-segment capture block: cathode
// code table (active-low, g..a), blank code and the frame FSM state type.
package seven_segment_pkg;

   localparam logic [7:0] BLANK_CODE = 8'hFF;

   localparam logic [6:0] SEG_CODE [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   typedef enum logic {IDLE, SCAN} state_e;

endpackage

// File: rtl/seven_segment_code_decoder.sv
// Combinational cathode-pattern to hex decoder; valid_o is low when the
// pattern is not one of the sixteen hex glyphs.
module seven_segment_code_decoder
   import seven_segment_pkg::*;
(
   input  logic [6:0] seg_i,
   output logic       valid_o,
   output logic [3:0] hex_o
);

   always_comb begin
      valid_o = 1'b0;
      hex_o   = 4'h0;
      for (int i = 0; i < 16; i++) begin
         if (seg_i == SEG_CODE[i]) begin
            valid_o = 1'b1;
            hex_o   = 4'(i);
         end
      end
   end

endmodule

// File: rtl/seven_segment_capture.sv
// Reconstructs frames from a multiplexed 8-digit seven-segment drive.
// Optional macro SEVEN_SEGMENT_DP_CAPTURE_EN enables decimal-point capture.
module seven_segment_capture
   import seven_segment_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1,
   parameter int IDLE_TIMEOUT  = 1024
) (
   input  logic        clk,
   input  logic        RESET,
   input  logic        CE,
   input  logic [7:0]  AN,
   input  logic [7:0]  SEG,
   output logic [31:0] NUMBER,
   output logic [7:0]  DIGIT_PRESENT,
   output logic [7:0]  DP,
   output logic        FRAME_VALID,
   output logic        error_out
);

   localparam int         IW       = $clog2(IDLE_TIMEOUT + 1);
   localparam logic [4:0] SETTLE_W = 5'(SETTLE_CYCLES);

   state_e        state_q, state_d;
   logic [15:0]   pair_q;
   logic [4:0]    settle_q, settle_d;
   logic [IW-1:0] idle_q, idle_d;
   logic [2:0]    last_q, last_d;
   logic [31:0]   sh_num_q, sh_num_d, num_q, num_d;
   logic [7:0]    sh_pres_q, sh_pres_d, pres_q, pres_d;
   logic          fv_q, fv_d, err_q, err_d;
   logic [3:0]    an_zeros;
   logic [2:0]    pos;
   logic          one_hot, sample, an_err, publish;
   logic          code_valid;
   logic [3:0]    code_hex;

   seven_segment_code_decoder u_dec (
      .seg_i   (SEG[6:0]),
      .valid_o (code_valid),
      .hex_o   (code_hex)
   );

   // pos is only meaningful when exactly one anode line is low
   always_comb begin
      an_zeros = '0;
      pos      = '0;
      for (int i = 7; i >= 0; i--) begin
         if (!AN[i]) begin
            an_zeros = an_zeros + 4'd1;
            pos      = 3'(i);
         end
      end
   end

   assign one_hot  = (an_zeros == 4'd1);
   assign settle_d = ({AN, SEG} != pair_q) ? 5'd1 :
                     (settle_q == 5'd16)   ? settle_q : settle_q + 5'd1;
   assign sample   = (settle_d == SETTLE_W) && one_hot;
   assign an_err   = (settle_d == SETTLE_W) && (an_zeros > 4'd1);

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      sh_num_d  = sh_num_q;
      sh_pres_d = sh_pres_q;
      num_d     = num_q;
      pres_d    = pres_q;
      idle_d    = '0;
      publish   = 1'b0;
      fv_d      = 1'b0;
      err_d     = err_q | an_err | (sample & ~code_valid);
      if (state_q == SCAN) begin
         if (sample) begin
            publish = (pos <= last_q);
         end else if (!one_hot) begin
            if (idle_q == IW'(IDLE_TIMEOUT - 1)) begin
               publish = 1'b1;
               state_d = IDLE;
            end else begin
               idle_d = idle_q + 1'b1;
            end
         end
      end
      if (publish) begin
         num_d     = sh_num_q;
         pres_d    = sh_pres_q;
         fv_d      = 1'b1;
         sh_num_d  = '0;
         sh_pres_d = '0;
      end
      // A wrapping sample seeds the new frame after the old one is cleared
      if (sample) begin
         state_d                     = SCAN;
         last_d                      = pos;
         sh_num_d[{pos, 2'b00} +: 4] = code_valid ? code_hex : 4'h0;
         sh_pres_d[pos]              = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         state_q   <= IDLE;
         pair_q    <= {BLANK_CODE, BLANK_CODE};
         settle_q  <= '0;
         idle_q    <= '0;
         last_q    <= '0;
         sh_num_q  <= '0;
         sh_pres_q <= '0;
         num_q     <= '0;
         pres_q    <= '0;
         fv_q      <= 1'b0;
         err_q     <= 1'b0;
      end else if (CE) begin
         state_q   <= state_d;
         pair_q    <= {AN, SEG};
         settle_q  <= settle_d;
         idle_q    <= idle_d;
         last_q    <= last_d;
         sh_num_q  <= sh_num_d;
         sh_pres_q <= sh_pres_d;
         num_q     <= num_d;
         pres_q    <= pres_d;
         fv_q      <= fv_d;
         err_q     <= err_d;
      end
   end

`ifdef SEVEN_SEGMENT_DP_CAPTURE_EN
   logic [7:0] sh_dp_q, sh_dp_d, dp_q, dp_d;

   always_comb begin
      sh_dp_d = publish ? 8'h00 : sh_dp_q;
      dp_d    = publish ? sh_dp_q : dp_q;
      if (sample) sh_dp_d[pos] = ~SEG[7];
   end

   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         sh_dp_q <= '0;
         dp_q    <= '0;
      end else if (CE) begin
         sh_dp_q <= sh_dp_d;
         dp_q    <= dp_d;
      end
   end

   assign DP = dp_q;
`else
   assign DP = 8'h00;
`endif

   assign NUMBER        = num_q;
   assign DIGIT_PRESENT = pres_q;
   assign FRAME_VALID   = fv_q;
   assign error_out     = err_q;

endmodule

// File: tb/tb_seven_segment_capture.sv
// Bench for seven_segment_capture: directed frames with literal expectations
// plus randomized drive checked every cycle against a behavioural frame model.
module tb_seven_segment_capture;

   localparam int SETTLE = 1;
   localparam int TMO    = 1024;

   logic        clk;
   logic        RESET, CE;
   logic [7:0]  AN, SEG;
   logic [31:0] NUMBER;
   logic [7:0]  DIGIT_PRESENT, DP;
   logic        FRAME_VALID, error_out;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   seven_segment_capture #(.SETTLE_CYCLES(SETTLE), .IDLE_TIMEOUT(TMO)) dut (
      .clk           (clk),
      .RESET         (RESET),
      .CE            (CE),
      .AN            (AN),
      .SEG           (SEG),
      .NUMBER        (NUMBER),
      .DIGIT_PRESENT (DIGIT_PRESENT),
      .DP            (DP),
      .FRAME_VALID   (FRAME_VALID),
      .error_out     (error_out)
   );

   logic [6:0] code_tab [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   // frame model state
   logic [7:0]  m_prev_an, m_prev_seg;
   int          m_run, m_idle, m_last;
   bit          m_active;
   logic [3:0]  m_dig [8];
   logic [7:0]  m_pres, m_dp;
   logic [31:0] e_num;
   logic [7:0]  e_pres, e_dp;
   logic        e_fv, e_err;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_prev_an  = 8'hFF;
      m_prev_seg = 8'hFF;
      m_run      = 0;
      m_idle     = 0;
      m_last     = 0;
      m_active   = 1'b0;
      for (int i = 0; i < 8; i++) m_dig[i] = 4'h0;
      m_pres = 8'h00;
      m_dp   = 8'h00;
      e_num  = 32'h0;
      e_pres = 8'h00;
      e_dp   = 8'h00;
      e_fv   = 1'b0;
      e_err  = 1'b0;
   endtask

   task automatic model_publish();
      for (int i = 0; i < 8; i++) begin
         e_num[4*i +: 4] = m_dig[i];
         m_dig[i] = 4'h0;
      end
      e_pres = m_pres;
      e_dp   = m_dp;
      m_pres = 8'h00;
      m_dp   = 8'h00;
   endtask

   task automatic model_step();
      int         zeros, p;
      bit         fv, ok;
      logic [3:0] val;
      if (CE !== 1'b1) return;
      fv = 1'b0;
      if (AN == m_prev_an && SEG == m_prev_seg) begin
         if (m_run < 100) m_run++;
      end else begin
         m_run = 1;
      end
      m_prev_an  = AN;
      m_prev_seg = SEG;
      zeros = 0;
      p     = 0;
      for (int i = 0; i < 8; i++) begin
         if (!AN[i]) begin
            zeros++;
            p = i;
         end
      end
      if (!m_active || zeros == 1) m_idle = 0;
      else m_idle++;
      if (m_run == SETTLE && zeros > 1) e_err = 1'b1;
      if (m_run == SETTLE && zeros == 1) begin
         ok  = 1'b0;
         val = 4'h0;
         for (int c = 0; c < 16; c++) begin
            if (SEG[6:0] == code_tab[c]) begin
               ok  = 1'b1;
               val = c[3:0];
            end
         end
         if (!ok) e_err = 1'b1;
         if (m_active && p <= m_last) begin
            model_publish();
            fv = 1'b1;
         end
         m_active = 1'b1;
         m_last   = p;
         m_dig[p] = val;
         m_pres[p] = 1'b1;
`ifdef SEVEN_SEGMENT_DP_CAPTURE_EN
         m_dp[p] = ~SEG[7];
`endif
      end else if (m_active && m_idle >= TMO) begin
         model_publish();
         fv       = 1'b1;
         m_active = 1'b0;
         m_idle   = 0;
      end
      e_fv = fv;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("model.NUMBER", NUMBER, e_num);
         check("model.DIGIT_PRESENT", 32'(DIGIT_PRESENT), 32'(e_pres));
         check("model.DP", 32'(DP), 32'(e_dp));
         check("model.FRAME_VALID", 32'(FRAME_VALID), 32'(e_fv));
         check("model.error_out", 32'(error_out), 32'(e_err));
      end
   end

   task automatic cyc(input logic [7:0] an, input logic [7:0] seg, input logic ce);
      @(negedge clk);
      AN  = an;
      SEG = seg;
      CE  = ce;
      @(posedge clk);
      model_step();
   endtask

   task automatic show(input int pos, input logic [3:0] h, input int n);
      logic [7:0] an;
      an = ~(8'b1 << pos);
      repeat (n) cyc(an, {1'b1, code_tab[h]}, 1'b1);
   endtask

   // drives every unmasked digit once in ascending order, 3 cycles each
   task automatic scan(input logic [31:0] v, input logic [7:0] mask);
      for (int i = 0; i < 8; i++) begin
         if (!mask[i]) show(i, v[4*i +: 4], 3);
      end
   endtask

   task automatic do_reset();
      chk_en = 1'b0;
      AN     = 8'hFF;
      SEG    = 8'hFF;
      CE     = 1'b1;
      RESET  = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1 RESET = 1'b0;
      chk_en = 1'b1;
   endtask

   task automatic random_phase(input bit allow_bad, input int events);
      int         r, pos, a, b, h, hold;
      logic [7:0] an, seg;
      logic       dpb, ce;
      pos = 0;
      for (int n = 0; n < events; n++) begin
         if (n % 700 == 350) begin
            repeat (TMO + 3) cyc(8'hFF, 8'hFF, 1'b1);
         end
         r = $urandom_range(0, 99);
         if (r < 8) begin
            an = 8'hFF;
         end else if (allow_bad && r < 11) begin
            a  = $urandom_range(0, 7);
            b  = (a + 1 + $urandom_range(0, 6)) % 8;
            an = ~((8'b1 << a) | (8'b1 << b));
         end else begin
            if ($urandom_range(0, 9) < 8) pos = (pos + 1) % 8;
            else pos = $urandom_range(0, 7);
            an = ~(8'b1 << pos);
         end
         h   = $urandom_range(0, 15);
         dpb = 1'($urandom_range(0, 1));
         seg = {dpb, code_tab[h]};
         if (allow_bad && $urandom_range(0, 19) == 0) seg = 8'($urandom);
         hold = $urandom_range(1, 3);
         for (int k = 0; k < hold; k++) begin
            ce = ($urandom_range(0, 9) != 0);
            cyc(an, seg, ce);
         end
      end
   endtask

   initial begin
      RESET = 1'b1;
      CE    = 1'b1;
      AN    = 8'hFF;
      SEG   = 8'hFF;
      do_reset();
      check("reset.NUMBER", NUMBER, 32'h0);
      check("reset.DIGIT_PRESENT", 32'(DIGIT_PRESENT), 32'h0);
      check("reset.DP", 32'(DP), 32'h0);
      check("reset.FRAME_VALID", 32'(FRAME_VALID), 32'h0);
      check("reset.error_out", 32'(error_out), 32'h0);

      // full scan, wrap on digit 0
      scan(32'h89AB_CDEF, 8'h00);
      show(0, 4'hF, 1);
      #1;
      check("scan.FRAME_VALID", 32'(FRAME_VALID), 32'h1);
      check("scan.NUMBER", NUMBER, 32'h89AB_CDEF);
      check("scan.DIGIT_PRESENT", 32'(DIGIT_PRESENT), 32'hFF);
      check("scan.error_out", 32'(error_out), 32'h0);
      show(0, 4'hF, 1);
      #1;
      check("scan.single_pulse", 32'(FRAME_VALID), 32'h0);
      scan(32'h89AB_CDE0, 8'h01);
      show(0, 4'hF, 1);
      #1;
      check("scan2.FRAME_VALID", 32'(FRAME_VALID), 32'h1);
      check("scan2.NUMBER", NUMBER, 32'h89AB_CDEF);

      // masked digits
      do_reset();
      scan(32'h1111_1111, 8'b0010_1100);
      show(0, 4'h1, 1);
      #1;
      check("mask.DIGIT_PRESENT", 32'(DIGIT_PRESENT), 32'hD3);
      check("mask.NUMBER", NUMBER, 32'h1101_0011);

      // unknown glyph on digit 3
      do_reset();
      for (int i = 0; i < 8; i++) begin
         if (i == 3) repeat (3) cyc(8'hF7, 8'hFF, 1'b1);
         else show(i, 4'(8 + ((7 - i) % 8)), 3);
      end
      show(0, 4'hF, 1);
      #1;
      check("badcode.error_out", 32'(error_out), 32'h1);
      check("badcode.NUMBER", NUMBER, 32'h89AB_0DEF);
      check("badcode.DIGIT_PRESENT", 32'(DIGIT_PRESENT), 32'hFF);
      scan(32'h89AB_CDE0, 8'h01);
      show(0, 4'hF, 1);
      #1;
      check("badcode.sticky", 32'(error_out), 32'h1);

      // two anodes active at once
      do_reset();
      cyc(8'hFC, 8'hC0, 1'b1);
      cyc(8'hFC, 8'hC0, 1'b1);
      #1;
      check("multi.error_out", 32'(error_out), 32'h1);
      check("multi.DIGIT_PRESENT", 32'(DIGIT_PRESENT), 32'h0);
      check("multi.FRAME_VALID", 32'(FRAME_VALID), 32'h0);

      // idle timeout after digit 4
      do_reset();
      scan(32'h7654_3210, 8'hE0);
      repeat (TMO - 1) cyc(8'hFF, 8'hFF, 1'b1);
      #1;
      check("timeout.early", 32'(FRAME_VALID), 32'h0);
      cyc(8'hFF, 8'hFF, 1'b1);
      #1;
      check("timeout.FRAME_VALID", 32'(FRAME_VALID), 32'h1);
      check("timeout.DIGIT_PRESENT", 32'(DIGIT_PRESENT), 32'h1F);
      check("timeout.NUMBER", NUMBER, 32'h0004_3210);
      show(2, 4'h2, 1);
      #1;
      check("timeout.idle_no_wrap", 32'(FRAME_VALID), 32'h0);
      show(1, 4'h1, 1);
      #1;
      check("timeout.restart", 32'(DIGIT_PRESENT), 32'h04);

      // reset in the middle of a frame
      do_reset();
      scan(32'h0054_3210, 8'hC0);
      do_reset();
      check("midreset.NUMBER", NUMBER, 32'h0);
      check("midreset.DIGIT_PRESENT", 32'(DIGIT_PRESENT), 32'h0);
      check("midreset.FRAME_VALID", 32'(FRAME_VALID), 32'h0);
      show(0, 4'h3, 1);
      #1;
      check("midreset.no_wrap", 32'(FRAME_VALID), 32'h0);
      scan(32'h89AB_CDE0, 8'h01);
      show(0, 4'hF, 1);
      #1;
      check("midreset.NUMBER_after", NUMBER, 32'h89AB_CDE3);
      check("midreset.DIGIT_PRESENT_after", 32'(DIGIT_PRESENT), 32'hFF);

      // randomized drive, first clean then with protocol faults
      do_reset();
      random_phase(1'b0, 1500);
      do_reset();
      random_phase(1'b1, 1500);

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
